control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  FSM controller for the multi-cycle MIPS-subset CPU. Decodes Opcode plus ALU flags (zero, sign).
//  Sequences IF/ID/EXE/MEM/WB and drives every datapath select/enable.
//  Sits between the instruction register and the PC, regfile, ALU, extender and data memory.
// PARAMETERS
//  none (state and opcode encodings are fixed localparams, listed below)
// PORTS
//  CLK        in   1  system clock; state updates on rising edge
//  Reset      in   1  asynchronous, active-high reset
//  Opcode     in   6  IR[31:26]
//  zero       in   1  ALU result == 0
//  sign       in   1  ALU result MSB
//  ALUSrcA    out  1  0=rs, 1=shamt (zero-extended)
//  ALUSrcB    out  1  0=rt, 1=extended immediate
//  DBDataSrc  out  1  regfile write data: 0=ALU result, 1=memory data
//  PCWre      out  1  PC write enable
//  IRWre      out  1  IR write enable
//  RegWre     out  1  regfile write enable
//  InsMemRW   out  1  instruction memory read (constant 1)
//  nRD        out  1  data memory read, active low
//  nWR        out  1  data memory write, active low
//  RegDst     out  2  write register: 00=$31, 01=rt, 10=rd
//  ExtSel     out  1  0=zero-extend, 1=sign-extend
//  PCSrc      out  2  00=PC+4, 01=PC+4+(simm<<2), 10=rs, 11={PC[31:28],addr,2'b00}
//  ALUOp      out  3  000 add, 001 sub, 010 sll(B<<A), 011 or, 100 and, 101 sltu, 110 slt, 111 xor
// BEHAVIOUR
//  Opcodes:
//   add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000,
//   slt 100110, slti 100111, sw 110000, lw 110001, beq 110100, bne 110101, bltz 110110,
//   j 111000, jr 111001, halt 111111.
//  States (3-bit): IF=000 ID=001 EXE_AL=110 WB_AL=111 EXE_BR=101 EXE_LS=010 MEM=011 WB_LD=100 HALT=
//   reset-only hold state (encoding as implemented).
//  Reset asserted: state=IF at once.
//   Outputs forced to PCWre=0, IRWre=0, RegWre=0, nRD=1, nWR=1, InsMemRW=1; all selects 0.
//  Outputs are combinational from (state, Opcode, zero, sign).
//  Default in every state: PCWre, IRWre, RegWre = 0; nRD = nWR = 1.
//  IF: IRWre=1 -> ID.
//  ID:
//   j    -> PCSrc=11, PCWre=1 -> IF.
//   jr   -> PCSrc=10, PCWre=1 -> IF.
//   halt -> HALT.
//   beq/bne/bltz -> EXE_BR.  sw/lw -> EXE_LS.  other listed ops -> EXE_AL.
//   Unlisted opcode: PCSrc=00, PCWre=1 -> IF (acts as nop).
//  EXE_AL: ALUOp per op; ALUSrcA=1 only for sll; ALUSrcB=1 for addi/ori/slti;
//   ExtSel=0 for ori, else 1 -> WB_AL.
//  WB_AL: RegWre=1, DBDataSrc=0; RegDst=10 (R-type) or 01 (I-type); PCSrc=00, PCWre=1 -> IF.
//  EXE_BR: ALUOp=001, ALUSrcB=0, ExtSel=1.
//   Taken when beq&zero, bne&!zero, or bltz&sign: PCSrc=01, else PCSrc=00.
//   PCWre=1 -> IF.
//  EXE_LS: ALUOp=000, ALUSrcB=1, ExtSel=1 -> MEM.
//  MEM:
//   sw: nWR=0, PCSrc=00, PCWre=1 -> IF.
//   lw: nRD=0 -> WB_LD.
//  WB_LD: nRD=0, DBDataSrc=1, RegWre=1, RegDst=01, PCSrc=00, PCWre=1 -> IF.
//  HALT: all enables 0; held until Reset.
//  Latency (cycles): j/jr 2; branch 3; R/I-ALU 4; sw 4; lw 5.
//   PCWre is high in exactly one cycle per instruction, the last one.
//  Reset mid-instruction: aborts immediately; nothing further is written.
// TESTING
//  Reset=1, then release; Opcode=000000 -> states IF,ID,EXE_AL,WB_AL,IF.
//   IRWre=1 only in IF; RegWre=1, RegDst=10, PCWre=1 only in WB_AL.
//  lw (110001) -> 5-cycle sequence; nRD=0 in MEM and WB_LD; DBDataSrc=1 and RegWre=1 in WB_LD.
//  sw (110000) -> nWR=0 only in MEM; RegWre never 1; PCWre=1 in MEM.
//  beq with zero=1 -> PCSrc=01 in EXE_BR; with zero=0 -> PCSrc=00.
//   bltz with sign=1 -> PCSrc=01.
//  j -> PCSrc=11 and PCWre=1 in ID.
//   halt -> PCWre stays 0 for 10+ cycles until Reset.
//  Assert Reset during EXE_AL -> outputs reset values immediately; restart from IF.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle FSM controller for the MIPS-subset CPU: sequences IF/ID/EXE/MEM/WB and drives datapath selects.
// Latency: j/jr 2 cycles, branch 3, ALU ops 4, sw 4, lw 5; PCWre pulses only in the last cycle of each instruction.
// No backpressure: the datapath is assumed single-cycle per state; halt parks the FSM until Reset.
//
// Ports:
//   CLK, Reset            clock; asynchronous active-high reset (state -> IF, outputs forced inactive)
//   Opcode[5:0]           IR[31:26]
//   zero, sign            ALU result flags (== 0, MSB) used to resolve branches
//   ALUSrcA/ALUSrcB       ALU operand selects (shamt / extended immediate)
//   DBDataSrc             regfile write data: ALU result or memory data
//   PCWre/IRWre/RegWre    PC, IR and regfile write enables
//   InsMemRW              instruction memory read, tied high
//   nRD/nWR               data memory read/write strobes, active low
//   RegDst[1:0]           write register: 00=$31, 01=rt, 10=rd
//   ExtSel                immediate extension: 0=zero, 1=sign
//   PCSrc[1:0]            next PC: PC+4, branch target, rs, jump target
//   ALUOp[2:0]            add/sub/sll/or/and/sltu/slt/xor
module control_unit (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       zero,
    input  logic       sign,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic       DBDataSrc,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       InsMemRW,
    output logic       nRD,
    output logic       nWR,
    output logic [1:0] RegDst,
    output logic       ExtSel,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUOp
);

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLT  = 6'b100110;
    localparam logic [5:0] OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_BNE  = 6'b110101;
    localparam logic [5:0] OP_BLTZ = 6'b110110;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b110;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_RS  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    // The eight 3-bit codes are all taken by working states, so HALT sits
    // in a fourth bit; the low three bits keep the documented encodings.
    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_t;

    state_t state;

    logic is_alu_op;
    logic is_branch;
    logic is_ldst;
    logic is_rtype;
    logic br_taken;

    always_comb begin
        is_alu_op = (Opcode == OP_ADD)  || (Opcode == OP_SUB) || (Opcode == OP_ADDI) ||
                    (Opcode == OP_OR)   || (Opcode == OP_AND) || (Opcode == OP_ORI)  ||
                    (Opcode == OP_SLL)  || (Opcode == OP_SLT) || (Opcode == OP_SLTI);
        is_rtype  = (Opcode == OP_ADD)  || (Opcode == OP_SUB) || (Opcode == OP_OR)   ||
                    (Opcode == OP_AND)  || (Opcode == OP_SLL) || (Opcode == OP_SLT);
        is_branch = (Opcode == OP_BEQ)  || (Opcode == OP_BNE) || (Opcode == OP_BLTZ);
        is_ldst   = (Opcode == OP_SW)   || (Opcode == OP_LW);
        br_taken  = ((Opcode == OP_BEQ)  &&  zero) ||
                    ((Opcode == OP_BNE)  && !zero) ||
                    ((Opcode == OP_BLTZ) &&  sign);
    end

    // State register and transitions.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= S_IF;
        end else begin
            case (state)
                S_IF: state <= S_ID;
                S_ID: begin
                    if (Opcode == OP_HALT)  state <= S_HALT;
                    else if (is_branch)     state <= S_EXE_BR;
                    else if (is_ldst)       state <= S_EXE_LS;
                    else if (is_alu_op)     state <= S_EXE_AL;
                    else                    state <= S_IF;   // j, jr and unknown opcodes retire here
                end
                S_EXE_AL: state <= S_WB_AL;
                S_WB_AL:  state <= S_IF;
                S_EXE_BR: state <= S_IF;
                S_EXE_LS: state <= S_MEM;
                S_MEM:    state <= (Opcode == OP_LW) ? S_WB_LD : S_IF;
                S_WB_LD:  state <= S_IF;
                S_HALT:   state <= S_HALT;
                default:  state <= S_IF;
            endcase
        end
    end

    // Control outputs decode from the current state and the live opcode/flags.
    // Reset gates them directly so a mid-instruction abort writes nothing,
    // even in the cycle before the state register would otherwise change.
    always_comb begin
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        DBDataSrc = 1'b0;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        InsMemRW  = 1'b1;
        nRD       = 1'b1;
        nWR       = 1'b1;
        RegDst    = 2'b00;
        ExtSel    = 1'b0;
        PCSrc     = PC_SEQ;
        ALUOp     = ALU_ADD;

        if (!Reset) begin
            case (state)
                S_IF: IRWre = 1'b1;
                S_ID: begin
                    if (Opcode == OP_J) begin
                        PCSrc = PC_JMP;
                        PCWre = 1'b1;
                    end else if (Opcode == OP_JR) begin
                        PCSrc = PC_RS;
                        PCWre = 1'b1;
                    end else if (!(is_alu_op || is_branch || is_ldst || Opcode == OP_HALT)) begin
                        PCSrc = PC_SEQ;
                        PCWre = 1'b1;
                    end
                end
                S_EXE_AL: begin
                    case (Opcode)
                        OP_SUB:          ALUOp = ALU_SUB;
                        OP_OR, OP_ORI:   ALUOp = ALU_OR;
                        OP_AND:          ALUOp = ALU_AND;
                        OP_SLL:          ALUOp = ALU_SLL;
                        OP_SLT, OP_SLTI: ALUOp = ALU_SLT;
                        default:         ALUOp = ALU_ADD;
                    endcase
                    ALUSrcA = (Opcode == OP_SLL);
                    ALUSrcB = (Opcode == OP_ADDI) || (Opcode == OP_ORI) || (Opcode == OP_SLTI);
                    ExtSel  = (Opcode != OP_ORI);
                end
                S_WB_AL: begin
                    RegWre = 1'b1;
                    RegDst = is_rtype ? 2'b10 : 2'b01;
                    PCSrc  = PC_SEQ;
                    PCWre  = 1'b1;
                end
                S_EXE_BR: begin
                    ALUOp  = ALU_SUB;
                    ExtSel = 1'b1;
                    PCSrc  = br_taken ? PC_BR : PC_SEQ;
                    PCWre  = 1'b1;
                end
                S_EXE_LS: begin
                    ALUOp   = ALU_ADD;
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                end
                S_MEM: begin
                    if (Opcode == OP_LW) begin
                        nRD = 1'b0;
                    end else begin
                        nWR   = 1'b0;
                        PCSrc = PC_SEQ;
                        PCWre = 1'b1;
                    end
                end
                S_WB_LD: begin
                    nRD       = 1'b0;
                    DBDataSrc = 1'b1;
                    RegWre    = 1'b1;
                    RegDst    = 2'b01;
                    PCSrc     = PC_SEQ;
                    PCWre     = 1'b1;
                end
                default: ;  // HALT: every enable stays inactive
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: per-instruction expected control vectors are queued, then compared cycle by cycle.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Also exercises reset at start, reset mid-instruction, halt hold and restart.
module tb_control_unit;

    typedef struct packed {
        logic       alusrca;
        logic       alusrcb;
        logic       dbdatasrc;
        logic       pcwre;
        logic       irwre;
        logic       regwre;
        logic       insmemrw;
        logic       nrd;
        logic       nwr;
        logic [1:0] regdst;
        logic       extsel;
        logic [1:0] pcsrc;
        logic [2:0] aluop;
    } ctl_t;

    logic       CLK;
    logic       Reset;
    logic [5:0] Opcode;
    logic       zero;
    logic       sign;
    logic       ALUSrcA, ALUSrcB, DBDataSrc, PCWre, IRWre, RegWre, InsMemRW, nRD, nWR, ExtSel;
    logic [1:0] RegDst, PCSrc;
    logic [2:0] ALUOp;

    ctl_t dut_vec;
    ctl_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    control_unit dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero), .sign(sign),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .PCWre(PCWre),
        .IRWre(IRWre), .RegWre(RegWre), .InsMemRW(InsMemRW), .nRD(nRD), .nWR(nWR),
        .RegDst(RegDst), .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp)
    );

    assign dut_vec = {ALUSrcA, ALUSrcB, DBDataSrc, PCWre, IRWre, RegWre, InsMemRW,
                      nRD, nWR, RegDst, ExtSel, PCSrc, ALUOp};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input ctl_t got, input ctl_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    endtask

    // Inactive vector: also the value expected while Reset is high.
    function automatic ctl_t idle_vec();
        ctl_t v;
        v = '0;
        v.insmemrw = 1'b1;
        v.nrd      = 1'b1;
        v.nwr      = 1'b1;
        return v;
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            6'b000001:           return 3'b001;
            6'b010000, 6'b010010: return 3'b011;
            6'b010001:           return 3'b100;
            6'b011000:           return 3'b010;
            6'b100110, 6'b100111: return 3'b110;
            default:             return 3'b000;
        endcase
    endfunction

    // Queue the expected per-cycle vectors of one instruction, starting at IF.
    task automatic push_instr(input logic [5:0] op, input logic z, input logic s);
        ctl_t v;
        logic rt, it;
        rt = (op == 6'b000000) || (op == 6'b000001) || (op == 6'b010000) ||
             (op == 6'b010001) || (op == 6'b011000) || (op == 6'b100110);
        it = (op == 6'b000010) || (op == 6'b010010) || (op == 6'b100111);
        v = idle_vec(); v.irwre = 1'b1; exp_q.push_back(v);            // IF
        v = idle_vec();
        if (op == 6'b111000) begin
            v.pcsrc = 2'b11; v.pcwre = 1'b1; exp_q.push_back(v);
        end else if (op == 6'b111001) begin
            v.pcsrc = 2'b10; v.pcwre = 1'b1; exp_q.push_back(v);
        end else if (op == 6'b111111) begin
            exp_q.push_back(v);
            for (int i = 0; i < 12; i++) exp_q.push_back(idle_vec());   // parked in HALT
        end else if (rt || it) begin
            exp_q.push_back(v);                                        // ID
            v.aluop = alu_of(op); v.alusrca = (op == 6'b011000);
            v.alusrcb = it; v.extsel = (op != 6'b010010);
            exp_q.push_back(v);                                        // EXE_AL
            v = idle_vec(); v.regwre = 1'b1; v.regdst = rt ? 2'b10 : 2'b01; v.pcwre = 1'b1;
            exp_q.push_back(v);                                        // WB_AL
        end else if (op == 6'b110100 || op == 6'b110101 || op == 6'b110110) begin
            exp_q.push_back(v);
            v.aluop = 3'b001; v.extsel = 1'b1; v.pcwre = 1'b1;
            v.pcsrc = ((op == 6'b110100 && z) || (op == 6'b110101 && !z) ||
                       (op == 6'b110110 && s)) ? 2'b01 : 2'b00;
            exp_q.push_back(v);                                        // EXE_BR
        end else if (op == 6'b110000 || op == 6'b110001) begin
            exp_q.push_back(v);
            v.aluop = 3'b000; v.alusrcb = 1'b1; v.extsel = 1'b1;
            exp_q.push_back(v);                                        // EXE_LS
            v = idle_vec();
            if (op == 6'b110000) begin
                v.nwr = 1'b0; v.pcwre = 1'b1; exp_q.push_back(v);
            end else begin
                v.nrd = 1'b0; exp_q.push_back(v);                      // MEM
                v.dbdatasrc = 1'b1; v.regwre = 1'b1; v.regdst = 2'b01; v.pcwre = 1'b1;
                exp_q.push_back(v);                                    // WB_LD
            end
        end else begin
            v.pcwre = 1'b1; exp_q.push_back(v);                        // unknown opcode: nop
        end
    endtask

    // Called 1 ns after a rising edge; returns 1 ns after the edge ending the instruction.
    task automatic run(input string name, input logic [5:0] op, input logic z, input logic s);
        ctl_t e;
        int   c;
        Opcode = op; zero = z; sign = s;
        push_instr(op, z, s);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            check($sformatf("%s c%0d", name, c), dut_vec, e);
            c++;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        ctl_t e;
        Reset = 1'b1; Opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
        #3 check("reset_init", dut_vec, idle_vec());
        @(posedge CLK); #1 Reset = 1'b0;

        run("add",  6'b000000, 1'b0, 1'b0);
        run("sub",  6'b000001, 1'b1, 1'b1);
        run("addi", 6'b000010, 1'b0, 1'b0);
        run("or",   6'b010000, 1'b0, 1'b0);
        run("and",  6'b010001, 1'b0, 1'b0);
        run("ori",  6'b010010, 1'b0, 1'b0);
        run("sll",  6'b011000, 1'b0, 1'b0);
        run("slt",  6'b100110, 1'b0, 1'b1);
        run("slti", 6'b100111, 1'b0, 1'b0);
        run("lw",   6'b110001, 1'b0, 1'b0);
        run("sw",   6'b110000, 1'b0, 1'b0);
        run("beq_t",  6'b110100, 1'b1, 1'b0);
        run("beq_nt", 6'b110100, 1'b0, 1'b1);
        run("bne_t",  6'b110101, 1'b0, 1'b0);
        run("bne_nt", 6'b110101, 1'b1, 1'b0);
        run("bltz_t", 6'b110110, 1'b0, 1'b1);
        run("bltz_nt",6'b110110, 1'b1, 1'b0);
        run("j",    6'b111000, 1'b0, 1'b0);
        run("jr",   6'b111001, 1'b0, 1'b0);
        run("nop",  6'b001111, 1'b0, 1'b0);

        // Abort an add in EXE_AL: outputs must drop to reset values without a clock edge.
        Opcode = 6'b000000; zero = 1'b0; sign = 1'b0;
        push_instr(6'b000000, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            e = exp_q.pop_front();
            check($sformatf("abort c%0d", k), dut_vec, e);
            if (k < 2) begin
                @(posedge CLK); #1;
            end
        end
        exp_q.delete();
        #1 Reset = 1'b1;
        #1 check("abort_reset", dut_vec, idle_vec());
        @(posedge CLK); #1 Reset = 1'b0;
        run("after_abort", 6'b000001, 1'b0, 1'b0);

        // Halt holds with PCWre low until Reset, then execution restarts from IF.
        run("halt", 6'b111111, 1'b0, 1'b0);
        #1 Reset = 1'b1;
        #1 check("halt_reset", dut_vec, idle_vec());
        @(posedge CLK); #1 Reset = 1'b0;
        run("after_halt", 6'b110001, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
